udp_rx_mport: RTL and testbench

Parametrised successor of the single-port GMII UDP receiver: parses preamble/SFD, Ethernet II, IPv4 and UDP headers from a byte-wide GMII stream and delivers the UDP payload as a byte stream. Adds IPv4 option skipping (any IHL), IPv4 header checksum verification, destination-port filtering against a table of up to 8 ports with channel-index output, source address/port reporting, truncated-frame abort and a dropped-frame counter. Sits between the GMII RX front end and the per-port payload consumers (OSD/command decoders).

---
 rtl/udp_rx_pkg.sv | 29 ++
 rtl/ip_hdr_csum.sv | 41 ++++
 rtl/udp_rx_mport.sv | 228 ++++++++++++++++++++++
 tb/tb_udp_rx_mport.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_rx_pkg.sv
// Shared types and constants for the multi-port GMII UDP receiver.
package udp_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    ETH_HEAD,
    IP_HEAD,
    IP_OPT,
    UDP_HEAD,
    RX_DATA,
    RX_END
  } rx_state_e;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
  localparam logic [15:0] PREAMBLE_LEN  = 16'd7;
  localparam logic [15:0] ETH_HDR_LEN   = 16'd14;
  localparam logic [15:0] IP_HDR_LEN    = 16'd20;
  localparam logic [15:0] UDP_HDR_LEN   = 16'd8;

  // Ones-complement add with end-around carry; cannot overflow twice.
  function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/ip_hdr_csum.sv
// IPv4 header checksum accumulator: pairs bytes into big-endian words and
// flags a correct header while its final byte is on the input.
module ip_hdr_csum
  import udp_rx_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       vld_i,
  input  logic [7:0] byte_i,
  output logic       ok_o
);

  logic [15:0] sum_q;
  logic [15:0] sum_d;
  logic [7:0]  hi_q;
  logic        odd_q;

  assign sum_d = csum_add(sum_q, {hi_q, byte_i});
  assign ok_o  = odd_q && (sum_d == 16'hFFFF);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q <= '0;
      hi_q  <= '0;
      odd_q <= 1'b0;
    end else if (clr_i) begin
      sum_q <= '0;
      odd_q <= 1'b0;
    end else if (vld_i) begin
      if (odd_q) begin
        sum_q <= sum_d;
        odd_q <= 1'b0;
      end else begin
        hi_q  <= byte_i;
        odd_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/udp_rx_mport.sv
// GMII UDP receiver: preamble/Ethernet/IPv4(+options)/UDP parsing, checksum
// and port-table filtering, payload streaming with drop/abort reporting.
module udp_rx_mport
  import udp_rx_pkg::*;
#(
  parameter logic [47:0]              BOARD_MAC     = 48'h00_11_22_33_44_55,
  parameter logic [31:0]              BOARD_IP      = {8'd192, 8'd168, 8'd1, 8'd10},
  parameter int unsigned              NUM_PORTS     = 2,
  parameter logic [NUM_PORTS*16-1:0]  PORT_LIST     = {16'd1234, 16'd5000},
  parameter bit                       CHECK_IP_CSUM = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        gmii_rxd_valid,
  input  logic [7:0]  gmii_rxd_data,
  output logic        rec_pkt_start,
  output logic        rec_pkt_done,
  output logic        rec_pkt_abort,
  output logic        rec_en,
  output logic [7:0]  rec_data,
  output logic [2:0]  rec_chan,
  output logic [15:0] rec_dest_port,
  output logic [15:0] rec_src_port,
  output logic [31:0] rec_src_ip,
  output logic [15:0] rec_byte_num,
  output logic [15:0] drop_cnt
);

  rx_state_e   state_q;
  logic [15:0] cnt_q;
  logic [3:0]  ihl_q;
  logic        uni_ok_q, bc_ok_q;
  logic [31:0] src_ip_q;
  logic [15:0] sport_q, dport_q, ulen_q;

  logic        start_q, done_q, abort_q, en_q;
  logic [7:0]  data_q;
  logic [2:0]  chan_q;
  logic [15:0] out_dport_q, out_sport_q, byte_num_q, drop_cnt_q;
  logic [31:0] out_ip_q;

  logic        csum_ok, csum_bad, uni_m, bc_m, fail, drop_inc, port_hit;
  logic [2:0]  port_idx;
  logic [15:0] opt_len;
  logic [47:0] mac_sh;
  logic [31:0] ip_sh;

  ip_hdr_csum u_csum (
    .clk_i  (clk),
    .rst_i  (reset),
    .clr_i  (state_q == ETH_HEAD),
    .vld_i  (gmii_rxd_valid && (state_q == IP_HEAD || state_q == IP_OPT)),
    .byte_i (gmii_rxd_data),
    .ok_o   (csum_ok)
  );

  assign opt_len  = {10'd0, ihl_q - 4'd5, 2'b00};
  assign mac_sh   = BOARD_MAC << {cnt_q[2:0], 3'b000};
  assign ip_sh    = BOARD_IP << {cnt_q[1:0], 3'b000};
  assign csum_bad = CHECK_IP_CSUM && !csum_ok;

  // Lowest matching table index wins.
  always_comb begin
    port_hit = 1'b0;
    port_idx = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!port_hit && dport_q == PORT_LIST[16*i +: 16]) begin
        port_hit = 1'b1;
        port_idx = 3'(i);
      end
    end
  end

  always_comb begin
    uni_m = (cnt_q == '0 || uni_ok_q) && gmii_rxd_data == mac_sh[47:40];
    bc_m  = (cnt_q == '0 || bc_ok_q) && gmii_rxd_data == 8'hFF;
    fail  = 1'b0;
    case (state_q)
      PREAMBLE: fail = !(gmii_rxd_data == 8'h55 && cnt_q < PREAMBLE_LEN) &&
                       !(gmii_rxd_data == 8'hD5 && cnt_q == PREAMBLE_LEN);
      ETH_HEAD: begin
        if (cnt_q < 16'd6)       fail = !uni_m && !bc_m;
        else if (cnt_q == 16'd12) fail = gmii_rxd_data != ETH_TYPE_IPV4[15:8];
        else if (cnt_q == 16'd13) fail = gmii_rxd_data != ETH_TYPE_IPV4[7:0];
      end
      IP_HEAD: begin
        if (cnt_q == 16'd0)
          fail = gmii_rxd_data[7:4] != 4'd4 || gmii_rxd_data[3:0] < 4'd5;
        else if (cnt_q == 16'd9)
          fail = gmii_rxd_data != IP_PROTO_UDP;
        else if (cnt_q >= 16'd16)
          fail = gmii_rxd_data != ip_sh[31:24] ||
                 (cnt_q == IP_HDR_LEN - 16'd1 && ihl_q == 4'd5 && csum_bad);
      end
      IP_OPT:   fail = cnt_q == opt_len - 16'd1 && csum_bad;
      UDP_HEAD: fail = cnt_q == UDP_HDR_LEN - 16'd1 && (ulen_q < UDP_HDR_LEN || !port_hit);
      default:  fail = 1'b0;
    endcase
    fail     = fail && gmii_rxd_valid;
    drop_inc = fail || (!gmii_rxd_valid &&
               (state_q inside {PREAMBLE, ETH_HEAD, IP_HEAD, IP_OPT, UDP_HEAD}));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ihl_q       <= '0;
      uni_ok_q    <= 1'b0;
      bc_ok_q     <= 1'b0;
      src_ip_q    <= '0;
      sport_q     <= '0;
      dport_q     <= '0;
      ulen_q      <= '0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      en_q        <= 1'b0;
      data_q      <= '0;
      chan_q      <= '0;
      out_dport_q <= '0;
      out_sport_q <= '0;
      out_ip_q    <= '0;
      byte_num_q  <= '0;
      drop_cnt_q  <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      en_q    <= 1'b0;
      if (drop_inc && drop_cnt_q != '1)
        drop_cnt_q <= drop_cnt_q + 16'd1;

      if (!gmii_rxd_valid) begin
        if (state_q == RX_DATA) abort_q <= 1'b1;
        state_q <= IDLE;
      end else if (fail) begin
        state_q <= RX_END;
      end else begin
        case (state_q)
          IDLE: if (gmii_rxd_data == 8'h55) begin
            state_q <= PREAMBLE;
            cnt_q   <= 16'd1;
          end
          PREAMBLE: begin
            cnt_q <= cnt_q + 16'd1;
            if (gmii_rxd_data == 8'hD5) begin
              state_q <= ETH_HEAD;
              cnt_q   <= '0;
            end
          end
          ETH_HEAD: begin
            cnt_q <= cnt_q + 16'd1;
            if (cnt_q < 16'd6) begin
              uni_ok_q <= uni_m;
              bc_ok_q  <= bc_m;
            end
            if (cnt_q == ETH_HDR_LEN - 16'd1) begin
              state_q <= IP_HEAD;
              cnt_q   <= '0;
            end
          end
          IP_HEAD: begin
            cnt_q <= cnt_q + 16'd1;
            if (cnt_q == 16'd0) ihl_q <= gmii_rxd_data[3:0];
            if (cnt_q >= 16'd12 && cnt_q <= 16'd15)
              src_ip_q <= {src_ip_q[23:0], gmii_rxd_data};
            if (cnt_q == IP_HDR_LEN - 16'd1) begin
              state_q <= (ihl_q == 4'd5) ? UDP_HEAD : IP_OPT;
              cnt_q   <= '0;
            end
          end
          IP_OPT: begin
            cnt_q <= cnt_q + 16'd1;
            if (cnt_q == opt_len - 16'd1) begin
              state_q <= UDP_HEAD;
              cnt_q   <= '0;
            end
          end
          UDP_HEAD: begin
            cnt_q <= cnt_q + 16'd1;
            if (cnt_q <= 16'd1) sport_q <= {sport_q[7:0], gmii_rxd_data};
            else if (cnt_q <= 16'd3) dport_q <= {dport_q[7:0], gmii_rxd_data};
            else if (cnt_q <= 16'd5) ulen_q <= {ulen_q[7:0], gmii_rxd_data};
            if (cnt_q == UDP_HDR_LEN - 16'd1) begin
              start_q     <= 1'b1;
              chan_q      <= port_idx;
              out_dport_q <= dport_q;
              out_sport_q <= sport_q;
              out_ip_q    <= src_ip_q;
              byte_num_q  <= ulen_q - UDP_HDR_LEN;
              cnt_q       <= ulen_q - UDP_HDR_LEN;
              if (ulen_q == UDP_HDR_LEN) begin
                done_q  <= 1'b1;
                state_q <= RX_END;
              end else begin
                state_q <= RX_DATA;
              end
            end
          end
          RX_DATA: begin
            en_q   <= 1'b1;
            data_q <= gmii_rxd_data;
            cnt_q  <= cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
              done_q  <= 1'b1;
              state_q <= RX_END;
            end
          end
          default: state_q <= state_q;
        endcase
      end
    end
  end

  assign rec_pkt_start = start_q;
  assign rec_pkt_done  = done_q;
  assign rec_pkt_abort = abort_q;
  assign rec_en        = en_q;
  assign rec_data      = data_q;
  assign rec_chan      = chan_q;
  assign rec_dest_port = out_dport_q;
  assign rec_src_port  = out_sport_q;
  assign rec_src_ip    = out_ip_q;
  assign rec_byte_num  = byte_num_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_udp_rx_mport.sv
// Self-checking bench for udp_rx_mport: table of frames plus hand-written
// abort / back-to-back / reset sequences, payload bytes checked via a queue.
module tb_udp_rx_mport;

  logic        clk = 1'b0;
  logic        reset;
  logic        v;
  logic [7:0]  rxd;

  logic        rec_pkt_start, rec_pkt_done, rec_pkt_abort, rec_en;
  logic [7:0]  rec_data;
  logic [2:0]  rec_chan;
  logic [15:0] rec_dest_port, rec_src_port, rec_byte_num, drop_cnt;
  logic [31:0] rec_src_ip;

  logic        nc_start, nc_done, nc_abort, nc_en;
  logic [7:0]  nc_data;
  logic [2:0]  nc_chan;
  logic [15:0] nc_dport, nc_sport, nc_bnum, nc_drop;
  logic [31:0] nc_ip;

  always #5 clk = ~clk;

  udp_rx_mport #(.PORT_LIST({16'd5000, 16'd1234})) dut (
    .clk(clk), .reset(reset), .gmii_rxd_valid(v), .gmii_rxd_data(rxd),
    .rec_pkt_start(rec_pkt_start), .rec_pkt_done(rec_pkt_done),
    .rec_pkt_abort(rec_pkt_abort), .rec_en(rec_en), .rec_data(rec_data),
    .rec_chan(rec_chan), .rec_dest_port(rec_dest_port), .rec_src_port(rec_src_port),
    .rec_src_ip(rec_src_ip), .rec_byte_num(rec_byte_num), .drop_cnt(drop_cnt)
  );

  udp_rx_mport #(.PORT_LIST({16'd5000, 16'd1234}), .CHECK_IP_CSUM(1'b0)) dut_nc (
    .clk(clk), .reset(reset), .gmii_rxd_valid(v), .gmii_rxd_data(rxd),
    .rec_pkt_start(nc_start), .rec_pkt_done(nc_done), .rec_pkt_abort(nc_abort),
    .rec_en(nc_en), .rec_data(nc_data), .rec_chan(nc_chan), .rec_dest_port(nc_dport),
    .rec_src_port(nc_sport), .rec_src_ip(nc_ip), .rec_byte_num(nc_bnum), .drop_cnt(nc_drop)
  );

  int n_checks = 0, n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] frm[$];
  int pay_off, cur_plen;
  int en_cnt, start_cnt, done_cnt, abort_cnt, nc_en_cnt, nc_done_cnt;
  int exp_drop;
  logic align_ok;
  logic [7:0] exp_b;

  typedef struct {
    int dport; int ihl; int plen; bit bad; bit bcast; int chan; bit ok; bit nc;
  } vec_t;
  vec_t tv[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_cnt();
    en_cnt = 0; start_cnt = 0; done_cnt = 0; abort_cnt = 0;
    nc_en_cnt = 0; nc_done_cnt = 0;
  endtask

  task automatic build(input int dport, input int ihl, input int plen,
                       input bit bad, input bit bcast);
    logic [7:0]  h[60];
    logic [47:0] mac;
    logic [31:0] s;
    logic [15:0] cs;
    int tl, ulen;
    mac = 48'h00_11_22_33_44_55;
    tl = ihl * 4 + 8 + plen;
    ulen = 8 + plen;
    frm.delete();
    repeat (7) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    for (int i = 0; i < 6; i++) frm.push_back(bcast ? 8'hFF : mac[8*(5-i) +: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(8'(8'h02 + i));
    frm.push_back(8'h08); frm.push_back(8'h00);
    h[0] = 8'h40 | 8'(ihl); h[1] = 8'h00; h[2] = 8'(tl >> 8); h[3] = 8'(tl);
    h[4] = 8'h12; h[5] = 8'h34; h[6] = 8'h40; h[7] = 8'h00;
    h[8] = 8'd64; h[9] = 8'd17; h[10] = 8'h00; h[11] = 8'h00;
    h[12] = 8'd192; h[13] = 8'd168; h[14] = 8'd1; h[15] = 8'd77;
    h[16] = 8'd192; h[17] = 8'd168; h[18] = 8'd1; h[19] = 8'd10;
    for (int i = 20; i < ihl * 4; i++) h[i] = 8'(i * 7);
    s = 0;
    for (int i = 0; i < ihl * 4; i += 2) begin
      s = s + {16'h0, h[i], h[i+1]};
      s = 32'(s[15:0]) + 32'(s[31:16]);
    end
    cs = ~s[15:0];
    h[10] = cs[15:8];
    h[11] = bad ? (cs[7:0] ^ 8'h01) : cs[7:0];
    for (int i = 0; i < ihl * 4; i++) frm.push_back(h[i]);
    frm.push_back(8'h9C); frm.push_back(8'h40);
    frm.push_back(8'(dport >> 8)); frm.push_back(8'(dport));
    frm.push_back(8'(ulen >> 8)); frm.push_back(8'(ulen));
    frm.push_back(8'h00); frm.push_back(8'h00);
    pay_off = frm.size();
    for (int i = 0; i < plen; i++) frm.push_back(8'($urandom));
    repeat (4) frm.push_back(8'($urandom));
  endtask

  task automatic send(input int n, input bit deliver);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      v = 1'b1;
      rxd = frm[i];
      if (deliver && i >= pay_off && i < pay_off + cur_plen) exp_q.push_back(frm[i]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      v = 1'b0;
      rxd = 8'h00;
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (rec_en) begin
        en_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rec_data: got %0h, expected no payload byte", rec_data);
        end else begin
          exp_b = exp_q.pop_front();
          chk("rec_data", 32'(rec_data), 32'(exp_b));
        end
      end
      if (rec_pkt_start) start_cnt++;
      if (rec_pkt_done) begin
        done_cnt++;
        align_ok = rec_en ? (en_cnt == cur_plen) : (rec_pkt_start && cur_plen == 0);
        chk("done_align", 32'(align_ok), 32'd1);
      end
      if (rec_pkt_abort) begin
        abort_cnt++;
        chk("abort_en_low", 32'(rec_en), 32'd0);
      end
      if (nc_en) nc_en_cnt++;
      if (nc_done) nc_done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tv[0] = '{5000, 5, 18, 1'b0, 1'b0, 1, 1'b1, 1'b0};
    tv[1] = '{1234, 6, 10, 1'b0, 1'b0, 0, 1'b1, 1'b0};
    tv[2] = '{1234, 6, 10, 1'b1, 1'b0, 0, 1'b0, 1'b1};
    tv[3] = '{4000, 5, 6,  1'b0, 1'b0, 0, 1'b0, 1'b0};
    tv[4] = '{5000, 5, 3,  1'b0, 1'b1, 1, 1'b1, 1'b0};
    tv[5] = '{1234, 7, 0,  1'b0, 1'b0, 0, 1'b1, 1'b0};
    tv[6] = '{5000, 5, 1,  1'b0, 1'b0, 1, 1'b1, 1'b0};

    reset = 1'b1; v = 1'b0; rxd = 8'h00;
    exp_drop = 0; cur_plen = 0;
    clr_cnt();
    repeat (3) @(negedge clk);
    chk("rst_flags", 32'({rec_en, rec_pkt_start, rec_pkt_done, rec_pkt_abort, rec_chan}), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_src_ip", rec_src_ip, 32'd0);
    reset = 1'b0;

    for (int k = 0; k < 7; k++) begin
      clr_cnt();
      cur_plen = tv[k].plen;
      build(tv[k].dport, tv[k].ihl, tv[k].plen, tv[k].bad, tv[k].bcast);
      send(frm.size(), tv[k].ok);
      idle(1);
      settle();
      if (tv[k].ok) begin
        chk("start_cnt", 32'(start_cnt), 32'd1);
        chk("done_cnt", 32'(done_cnt), 32'd1);
        chk("en_cnt", 32'(en_cnt), 32'(tv[k].plen));
        chk("rec_chan", 32'(rec_chan), 32'(tv[k].chan));
        chk("rec_byte_num", 32'(rec_byte_num), 32'(tv[k].plen));
        chk("rec_dest_port", 32'(rec_dest_port), 32'(tv[k].dport));
        chk("rec_src_port", 32'(rec_src_port), 32'd40000);
        chk("rec_src_ip", rec_src_ip, {8'd192, 8'd168, 8'd1, 8'd77});
      end else begin
        exp_drop++;
        chk("drop_no_start", 32'(start_cnt), 32'd0);
        chk("drop_no_en", 32'(en_cnt), 32'd0);
        chk("drop_no_done", 32'(done_cnt), 32'd0);
      end
      chk("abort_cnt", 32'(abort_cnt), 32'd0);
      chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
      chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
      if (tv[k].nc) begin
        chk("nocsum_done", 32'(nc_done_cnt), 32'd1);
        chk("nocsum_en", 32'(nc_en_cnt), 32'(tv[k].plen));
      end
    end

    // Dropped frame immediately followed (one idle cycle) by a good one.
    clr_cnt();
    cur_plen = 0;
    build(4000, 5, 6, 1'b0, 1'b0);
    send(frm.size(), 1'b0);
    idle(1);
    cur_plen = 7;
    build(5000, 5, 7, 1'b0, 1'b0);
    send(frm.size(), 1'b1);
    idle(1);
    settle();
    exp_drop++;
    chk("b2b_start", 32'(start_cnt), 32'd1);
    chk("b2b_en", 32'(en_cnt), 32'd7);
    chk("b2b_done", 32'(done_cnt), 32'd1);
    chk("b2b_drop_cnt", 32'(drop_cnt), 32'(exp_drop));

    // Frame truncated after 5 of 18 payload bytes.
    clr_cnt();
    cur_plen = 18;
    build(5000, 5, 18, 1'b0, 1'b0);
    send(pay_off + 5, 1'b1);
    idle(1);
    settle();
    chk("abort_start", 32'(start_cnt), 32'd1);
    chk("abort_en", 32'(en_cnt), 32'd5);
    chk("abort_pulse", 32'(abort_cnt), 32'd1);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_drop_cnt", 32'(drop_cnt), 32'(exp_drop));

    clr_cnt();
    cur_plen = 4;
    build(1234, 5, 4, 1'b0, 1'b0);
    send(frm.size(), 1'b1);
    idle(1);
    settle();
    chk("post_abort_en", 32'(en_cnt), 32'd4);
    chk("post_abort_done", 32'(done_cnt), 32'd1);
    chk("post_abort_chan", 32'(rec_chan), 32'd0);

    // Reset in the middle of a payload.
    clr_cnt();
    cur_plen = 18;
    build(5000, 5, 18, 1'b0, 1'b0);
    send(pay_off + 5, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1; v = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_flags", 32'({rec_en, rec_pkt_start, rec_pkt_done, rec_pkt_abort, rec_chan}), 32'd0);
    chk("midrst_fields", 32'(rec_dest_port | rec_src_port | rec_byte_num | 16'(rec_data)), 32'd0);
    chk("midrst_src_ip", rec_src_ip, 32'd0);
    chk("midrst_drop_cnt", 32'(drop_cnt), 32'd0);
    exp_drop = 0;
    @(negedge clk);
    reset = 1'b0;

    clr_cnt();
    cur_plen = 12;
    build(5000, 5, 12, 1'b0, 1'b0);
    send(frm.size(), 1'b1);
    idle(1);
    settle();
    chk("post_rst_start", 32'(start_cnt), 32'd1);
    chk("post_rst_en", 32'(en_cnt), 32'd12);
    chk("post_rst_done", 32'(done_cnt), 32'd1);
    chk("post_rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("post_rst_q_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
